// File: rtl/irq_pend_pkg.sv
// ---------------------------------------------------------------------------
// irq_pend_pkg
// Shared constants and types for the interrupt pending controller.
//   N_REQ   : number of request sources
//   IDX_W   : width of the presented source index (clog2(N_REQ))
//   state_e : presenter FSM state (ST_IDLE, ST_PRESENT)
// ---------------------------------------------------------------------------
package irq_pend_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PRESENT = 1'b1
    } state_e;

endpackage : irq_pend_pkg

// File: rtl/irq_pending_ctrl_pri_sel_8.sv
// ---------------------------------------------------------------------------
// pri_sel_8
// Combinational highest-set-bit selector.
// Ports:
//   vec_i : candidate vector, bit 7 is highest priority
//   idx_o : position of the highest set bit (0 when vec_i is zero)
//   any_o : 1 when at least one bit of vec_i is set
// ---------------------------------------------------------------------------
module pri_sel_8
    import irq_pend_pkg::*;
(
    input  logic [N_REQ-1:0] vec_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    // Ascending scan: the last set bit seen is the highest one.
    always_comb begin
        idx_o = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (vec_i[i]) begin
                idx_o = IDX_W'(i);
            end
        end
    end

    assign any_o = |vec_i;

endmodule : pri_sel_8

// File: rtl/irq_pending_ctrl.sv
// ---------------------------------------------------------------------------
// irq_pending_ctrl
// Collects 8 request lines into a pending register and presents the highest
// priority unmasked pending source as a 3-bit index over valid/ready.
//
// Handshake: irq_valid rises only from IDLE and, once high, irq_idx is held
// stable until the cycle where irq_valid & irq_ready are both high at a clock
// edge; that edge clears the presented pending bit and returns to IDLE, so
// irq_valid is low for at least one cycle between transfers. irq_ready while
// irq_valid is low has no effect.
//
// Ports:
//   clk       : clock, all state on rising edge
//   rst       : synchronous active-high reset
//   req_in    : request lines (already synchronised)
//   mask      : 1 = source masked (still latched, never presented)
//   irq_valid : irq_idx holds a valid source index
//   irq_idx   : presented source index, 7 = highest priority
//   irq_ready : consumer accepts when irq_valid & irq_ready
//   pending   : raw pending register (mask not applied)
//   overflow  : sticky, an edge hit an already-pending source not being cleared
//   ovf_clr   : one-cycle pulse clearing overflow
//
// Build option: define IRQ_PEND_LEVEL_EN for level-sensitive capture
// (req_in pends directly, overflow tied to 0, ovf_clr ignored).
// ---------------------------------------------------------------------------
module irq_pending_ctrl
    import irq_pend_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req_in,
    input  logic [N_REQ-1:0] mask,
    output logic             irq_valid,
    output logic [IDX_W-1:0] irq_idx,
    input  logic             irq_ready,
    output logic [N_REQ-1:0] pending,
    output logic             overflow,
    input  logic             ovf_clr
);

    state_e           state_q, state_d;
    logic [N_REQ-1:0] req_q;
    logic [N_REQ-1:0] pending_q, pending_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             overflow_q, overflow_d;

    logic [N_REQ-1:0] rise;
    logic [N_REQ-1:0] clr;
    logic             accept;
    logic [IDX_W-1:0] win_idx;
    logic             win_any;

    pri_sel_8 u_pri_sel (
        .vec_i (pending_q & ~mask),
        .idx_o (win_idx),
        .any_o (win_any)
    );

`ifdef IRQ_PEND_LEVEL_EN
    assign rise = req_in;

    // Edge history and ovf_clr have no role in level capture.
    logic unused_ok;
    assign unused_ok = ^{req_q, ovf_clr};
`else
    assign rise = req_in & ~req_q;
`endif

    assign accept = (state_q == ST_PRESENT) && irq_ready;

    always_comb begin
        clr = '0;
        if (accept) begin
            clr[idx_q] = 1'b1;
        end
    end

    // A rise on a bit being cleared this cycle re-pends it (set wins).
    assign pending_d = (pending_q & ~clr) | rise;

`ifdef IRQ_PEND_LEVEL_EN
    assign overflow_d = 1'b0;
`else
    // New overflow event takes precedence over a simultaneous clear.
    assign overflow_d = (|(rise & pending_q & ~clr)) | (overflow_q & ~ovf_clr);
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            ST_IDLE: begin
                if (win_any) begin
                    idx_d   = win_idx;
                    state_d = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                if (irq_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // Load the live request level so a line already high across
            // reset is not seen as a fresh edge once reset is released.
            req_q      <= req_in;
            pending_q  <= '0;
            idx_q      <= '0;
            overflow_q <= 1'b0;
            state_q    <= ST_IDLE;
        end else begin
            req_q      <= req_in;
            pending_q  <= pending_d;
            idx_q      <= idx_d;
            overflow_q <= overflow_d;
            state_q    <= state_d;
        end
    end

    assign irq_valid = (state_q == ST_PRESENT);
    assign irq_idx   = idx_q;
    assign pending   = pending_q;
    assign overflow  = overflow_q;

endmodule : irq_pending_ctrl
